// File: rtl/register_file_param.sv
// Purpose : parametrised 1-write / 2-read register file with a sequential bulk-clear engine.
// Latency : reads registered, data visible 1 cycle after the address; a clear occupies DEPTH cycles.
// Backpr. : none on reads; writes and clear_req are dropped while busy=1 (no queuing).
//
// Ports:
//   Clk, Rst_n               - rising-edge clock, asynchronous active-low reset
//   En, reg_write            - write qualifier and write request (both needed)
//   write_reg, write_data    - write address / data
//   read_reg1, read_reg2     - read addresses (decode side)
//   clear_req                - one-cycle request to zero every register
//   read_data1, read_data2   - registered read data
//   busy, clear_done         - clear in progress / one-cycle completion pulse
module register_file_param #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 64,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              En,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic              clear_req,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy,
    output logic              clear_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One extra bit so the range check stays meaningful when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd1_nxt, rd2_nxt;
    logic              wr_acc;

    // Address is backed by real storage (in range and not the hardwired zero register).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_acc = En && reg_write && !busy && addr_ok(write_reg);

    // Clear engine next-state
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr == LAST) begin
                    state_nxt = ST_DONE;
                    ptr_nxt   = '0;   // keeps ptr within 0..DEPTH-1
                end else begin
                    ptr_nxt   = ptr + 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // busy/clear_done are registered from the next state so they line up with the state itself.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            busy       <= (state_nxt == ST_CLEAR);
            clear_done <= (state_nxt == ST_DONE);
        end
    end

    // Read path: zero while clearing, zero for unbacked addresses, optional same-edge forwarding.
    always_comb begin
        rd1_nxt = '0;
        rd2_nxt = '0;
        if (!busy && addr_ok(read_reg1)) begin
            if (BYPASS && wr_acc && (write_reg == read_reg1)) rd1_nxt = write_data;
            else                                              rd1_nxt = mem[read_reg1];
        end
        if (!busy && addr_ok(read_reg2)) begin
            if (BYPASS && wr_acc && (write_reg == read_reg2)) rd2_nxt = write_data;
            else                                              rd2_nxt = mem[read_reg2];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            read_data1 <= '0;
            read_data2 <= '0;
        end else begin
            read_data1 <= rd1_nxt;
            read_data2 <= rd2_nxt;
        end
    end

    // Storage: reset zeroes everything; the clear engine walks one entry per cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == ST_CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_acc) begin
            mem[write_reg] <= write_data;
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

    logic        Clk;
    logic        Rst_n;
    logic        En;
    logic        reg_write;
    logic [5:0]  write_reg;
    logic [63:0] write_data;
    logic [5:0]  read_reg1;
    logic [5:0]  read_reg2;
    logic        clear_req;

    logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, busy_b, done_a, done_b;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_mem [64];
    logic [63:0] exp_a1, exp_a2, exp_b1, exp_b2;

    register_file_param #(.BYPASS(1'b1)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .clear_req(clear_req),
        .read_data1(rd1_a), .read_data2(rd2_a), .busy(busy_a), .clear_done(done_a)
    );

    register_file_param #(.BYPASS(1'b0)) u_dut_nb (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .clear_req(clear_req),
        .read_data1(rd1_b), .read_data2(rd2_b), .busy(busy_b), .clear_done(done_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference read: register 0 is always zero, accepted writes forward only when bypass is on.
    function automatic logic [63:0] ref_read(input logic [5:0] a, input bit byp);
        logic wr;
        wr = En && reg_write && (write_reg != 6'd0);
        if (a == 6'd0) return 64'd0;
        if (byp && wr && (write_reg == a)) return write_data;
        return model_mem[a];
    endfunction

    // Computes expected outputs for the current (idle-engine) inputs, clocks once, updates the model.
    task automatic step_model();
        exp_a1 = ref_read(read_reg1, 1'b1);
        exp_a2 = ref_read(read_reg2, 1'b1);
        exp_b1 = ref_read(read_reg1, 1'b0);
        exp_b2 = ref_read(read_reg2, 1'b0);
        tick();
        if (En && reg_write && (write_reg != 6'd0)) model_mem[write_reg] = write_data;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 64; i++) model_mem[i] = 64'd0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; En = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0; clear_req = 1'b0;
        model_zero();
        #2;
        tick(); tick();
        checks++;
        if (rd1_a !== 64'd0 || rd2_a !== 64'd0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
            rd1_b !== 64'd0 || rd2_b !== 64'd0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd1=%h rd2=%h busy=%b done=%b, required all zero",
                     rd1_a, rd2_a, busy_a, done_a);
        end
        Rst_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            read_reg1 = 6'(a);
            read_reg2 = 6'(63 - a);
            step_model();
            checks++;
            if (rd1_a !== 64'd0 || rd2_a !== 64'd0 || rd1_b !== 64'd0 || rd2_b !== 64'd0 ||
                busy_a !== 1'b0 || done_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_read addr=%0d: rd1=%h rd2=%h busy=%b done=%b, required 0",
                         a, rd1_a, rd2_a, busy_a, done_a);
            end
        end
    endtask

    task automatic test_write_read();
        En = 1'b1; reg_write = 1'b1; write_reg = 6'd5; write_data = 64'hDEAD_BEEF_0123_4567;
        read_reg1 = 6'd0; read_reg2 = 6'd0;
        step_model();
        reg_write = 1'b0; read_reg1 = 6'd5;
        step_model();
        checks++;
        if (rd1_a !== 64'hDEAD_BEEF_0123_4567 || rd1_b !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL write_read: got %h / %h, required deadbeef01234567", rd1_a, rd1_b);
        end
    endtask

    task automatic test_gated();
        En = 1'b1; reg_write = 1'b1; write_reg = 6'd0; write_data = 64'hFF; read_reg1 = 6'd0;
        step_model();
        reg_write = 1'b0;
        step_model();
        checks++;
        if (rd1_a !== 64'd0 || rd1_b !== 64'd0) begin
            errors++;
            $display("FAIL zero_reg_write: got %h / %h, required 0", rd1_a, rd1_b);
        end
        En = 1'b0; reg_write = 1'b1; write_reg = 6'd7; write_data = 64'h1;
        step_model();
        En = 1'b1; reg_write = 1'b0; read_reg1 = 6'd7;
        step_model();
        checks++;
        if (rd1_a !== 64'd0 || rd1_b !== 64'd0) begin
            errors++;
            $display("FAIL en_low_write: got %h / %h, required 0", rd1_a, rd1_b);
        end
    endtask

    task automatic test_bypass();
        En = 1'b1; reg_write = 1'b1; write_reg = 6'd9; write_data = 64'h11;
        read_reg1 = 6'd0; read_reg2 = 6'd0;
        step_model();
        write_data = 64'h22; read_reg1 = 6'd9; read_reg2 = 6'd9;
        step_model();
        checks++;
        if (rd1_a !== 64'h22 || rd2_a !== 64'h22) begin
            errors++;
            $display("FAIL bypass_on: got %h %h, required 22 22", rd1_a, rd2_a);
        end
        checks++;
        if (rd1_b !== 64'h11 || rd2_b !== 64'h11) begin
            errors++;
            $display("FAIL bypass_off_old: got %h %h, required 11 11", rd1_b, rd2_b);
        end
        reg_write = 1'b0;
        step_model();
        checks++;
        if (rd1_b !== 64'h22 || rd2_b !== 64'h22 || rd1_a !== 64'h22 || rd2_a !== 64'h22) begin
            errors++;
            $display("FAIL bypass_off_new: got %h %h / %h %h, required all 22",
                     rd1_b, rd2_b, rd1_a, rd2_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            En         = 1'($urandom_range(0, 3) != 0);
            reg_write  = 1'($urandom_range(0, 1));
            write_reg  = 6'($urandom_range(0, 63));
            write_data = {$urandom, $urandom};
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 6'($urandom_range(0, 63));
            read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 6'($urandom_range(0, 63));
            step_model();
            checks++;
            if (rd1_a !== exp_a1 || rd2_a !== exp_a2) begin
                errors++;
                $display("FAIL random_bypass n=%0d: got %h %h, required %h %h",
                         n, rd1_a, rd2_a, exp_a1, exp_a2);
            end
            checks++;
            if (rd1_b !== exp_b1 || rd2_b !== exp_b2) begin
                errors++;
                $display("FAIL random_nobypass n=%0d: got %h %h, required %h %h",
                         n, rd1_b, rd2_b, exp_b1, exp_b2);
            end
        end
        reg_write = 1'b0;
        En = 1'b1;
    endtask

    task automatic test_clear();
        int cnt;
        En = 1'b1; reg_write = 1'b1;
        for (int i = 1; i < 64; i++) begin
            write_reg = 6'(i); write_data = 64'(i);
            step_model();
        end
        reg_write = 1'b0; read_reg1 = 6'd5; read_reg2 = 6'd63; clear_req = 1'b1;
        step_model();
        clear_req = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1 || rd1_a !== exp_a1 || rd2_a !== exp_a2) begin
            errors++;
            $display("FAIL clear_start: busy=%b rd1=%h rd2=%h, required busy=1 rd1=%h rd2=%h",
                     busy_a, rd1_a, rd2_a, exp_a1, exp_a2);
        end
        cnt = 0;
        read_reg1 = 6'd3;
        while (busy_a === 1'b1 && cnt < 200) begin
            cnt++;
            reg_write  = (cnt == 5);
            clear_req  = (cnt == 10);   // re-request while clearing must be ignored
            write_reg  = 6'd3;
            write_data = 64'h5;
            tick();
            checks++;
            if (rd1_a !== 64'd0 || rd2_a !== 64'd0 || rd1_b !== 64'd0 || busy_b !== busy_a) begin
                errors++;
                $display("FAIL clear_busy_read cyc=%0d: rd1=%h rd2=%h busy_b=%b, required 0 0 %b",
                         cnt, rd1_a, rd2_a, busy_b, busy_a);
            end
        end
        reg_write = 1'b0; clear_req = 1'b0;
        checks++;
        if (cnt !== 64) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d cycles, required 64", cnt);
        end
        checks++;
        if (done_a !== 1'b1 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL clear_done_pulse: got %b/%b, required 1", done_a, done_b);
        end
        model_zero();
        tick();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_end: done=%b busy=%b, required 0 0", done_a, busy_a);
        end
        for (int a = 0; a < 64; a++) begin
            read_reg1 = 6'(a); read_reg2 = 6'(63 - a);
            step_model();
            checks++;
            if (rd1_a !== 64'd0 || rd2_a !== 64'd0 || rd1_b !== 64'd0 || rd2_b !== 64'd0) begin
                errors++;
                $display("FAIL after_clear addr=%0d: rd1=%h rd2=%h, required 0", a, rd1_a, rd2_a);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        En = 1'b1; reg_write = 1'b1; write_reg = 6'd40; write_data = 64'hABC;
        step_model();
        reg_write = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midclear_busy: got %b, required 1", busy_a);
        end
        Rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || rd1_a !== 64'd0 || rd2_a !== 64'd0 ||
            busy_b !== 1'b0 || rd1_b !== 64'd0) begin
            errors++;
            $display("FAIL midclear_reset: busy=%b done=%b rd1=%h rd2=%h, required all 0",
                     busy_a, done_a, rd1_a, rd2_a);
        end
        tick();
        Rst_n = 1'b1;
        model_zero();
        for (int a = 0; a < 64; a++) begin
            read_reg1 = 6'(a); read_reg2 = 6'(63 - a);
            step_model();
            checks++;
            if (rd1_a !== 64'd0 || rd2_a !== 64'd0 || rd1_b !== 64'd0 || rd2_b !== 64'd0 ||
                busy_a !== 1'b0) begin
                errors++;
                $display("FAIL post_reset addr=%0d: rd1=%h rd2=%h busy=%b, required 0",
                         a, rd1_a, rd2_a, busy_a);
            end
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 64 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL reclear_len: got %0d cycles done=%b, required 64 cycles done=1",
                     cnt, done_a);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_gated();
        test_bypass();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the single-write, dual-read register file used by the datapath.
- Width, depth, hardwired-zero register 0 and write-to-read bypass are configurable.
- Adds an asynchronous active-low reset and a sequential bulk-clear engine with busy/done handshake.
- Sits between decode (read addresses) and writeback (write port); reads are registered, with 1-cycle latency.

Parameters:
- DATA_W, 64, width of each register and of the data ports.
- ADDR_W, 6, width of every register address port.
- DEPTH, 64, number of implemented registers; 2 <= DEPTH <= 2**ADDR_W.
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read output.

Ports:
- Clk, input, 1, rising-edge clock.
- Rst_n, input, 1, asynchronous active-low reset.
- En, input, 1, write enable qualifier; a write needs En and reg_write.
- reg_write, input, 1, write request.
- write_reg, input, ADDR_W, write address.
- write_data, input, DATA_W, write data.
- read_reg1, input, ADDR_W, read port 1 address.
- read_reg2, input, ADDR_W, read port 2 address.
- clear_req, input, 1, one-cycle request to zero all registers.
- read_data1, output, DATA_W, registered read data, port 1.
- read_data2, output, DATA_W, registered read data, port 2.
- busy, output, 1, high while a clear is in progress.
- clear_done, output, 1, one-cycle pulse when a clear completes.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - All DEPTH registers go to 0.
  - read_data1, read_data2, busy and clear_done go to 0.
  - FSM goes to IDLE and the clear pointer to 0.
  - Applies immediately, including mid-clear; operation resumes on the first rising Clk edge after Rst_n=1.
- Write: on a rising edge with En=1, reg_write=1 and busy=0, mem[write_reg] <= write_data. The write is discarded if:
  - write_reg >= DEPTH, or
  - ZERO_REG=1 and write_reg=0.
  En=0 or busy=1 discards the write.
- Read:
  - Every rising edge, read_dataN <= mem[read_regN], independent of En.
  - Value becomes visible 1 cycle after the address is presented.
  - Address >= DEPTH reads 0.
  - ZERO_REG=1 with address 0 reads 0.
- Bypass: when BYPASS=1 and an accepted write in the same edge targets read_regN, read_dataN <= write_data (new data).
  - When BYPASS=0, read_dataN <= the old contents.
  - Discarded writes are never forwarded.
  - Both ports may bypass simultaneously.
- While busy=1, read_data1 and read_data2 are loaded with 0.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clear_req=1 on an edge moves to CLEAR with ptr=0. A write accepted on that same edge is still performed; it is erased later by the clear.
  - CLEAR: busy=1. Each edge performs mem[ptr] <= 0 and ptr <= ptr+1. When ptr=DEPTH-1 the FSM moves to DONE. Takes exactly DEPTH cycles.
  - DONE: busy=0 and clear_done=1 for one cycle, then IDLE.
  - clear_req in CLEAR or DONE is ignored (no queuing).
  - The first post-clear read result appears on the edge after DONE.
- busy is a registered output derived from state; it asserts the cycle after clear_req is sampled.
- ptr has width ADDR_W and never exceeds DEPTH-1.
- All arithmetic is unsigned.

Test Plan:
- Reset and read: hold Rst_n=0, release, then read addresses 0..63 -> every read_data is 0 one cycle after its address; busy=0 and clear_done=0.
- Write then read: write 64'hDEAD_BEEF_0123_4567 to reg 5, then read_reg1=5 on the next cycle -> read_data1=64'hDEAD_BEEF_0123_4567 one cycle later.
- Gated and zero writes:
  - With ZERO_REG=1, write 64'hFF to reg 0 and read reg 0 -> 0.
  - En=0 write of 64'h1 to reg 7 -> reg 7 still reads 0.
- Bypass:
  - BYPASS=1: reg 9 holds 64'h11; write 64'h22 to reg 9 while read_reg1=read_reg2=9 -> both read_data=64'h22 next cycle.
  - BYPASS=0 instance, same stimulus -> both read 64'h11, then 64'h22 the following cycle.
- Clear: fill regs 1..63 with their own index, pulse clear_req.
  - busy=1 for exactly 64 cycles, then clear_done=1 for one cycle.
  - A write of 64'h5 to reg 3 during busy is ignored.
  - Afterwards every register reads 0.
- Reset mid-clear:
  - Pulse clear_req, drop Rst_n after 10 busy cycles -> busy=0 immediately, all regs read 0.
  - A new clear_req after release runs the full 64 cycles.
